// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: SLL / SRL / SRA / ROL applied as five
// binary-weighted stages (1, 2, 4, 8, 16 bits), one stage per clock,
// with a valid/ready handshake on both the request and result sides.
module shift_sequencer #(
    parameter bit FAST_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [4:0]  in_shamt,
    input  logic [1:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic [2:0]  stage
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t      state_r;
    logic [31:0] acc_r;
    logic [4:0]  shamt_r;
    logic [1:0]  op_r;
    logic [2:0]  k_r;
    logic [31:0] out_data_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic        busy_r;
    logic [2:0]  stage_r;
    logic [31:0] acc_next_s;
    logic [4:0]  stage_amt_s;

    // One shift stage of a fixed amount; ROL wraps bits leaving bit 31 into bit 0.
    function automatic logic [31:0] shift_stage(input logic [31:0] a,
                                                input logic [1:0]  op,
                                                input logic [4:0]  sh);
        logic [31:0] r;
        case (op)
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = $signed(a) >>> sh;
            default: r = (a << sh) | (a >> (6'd32 - {1'b0, sh}));
        endcase
        return r;
    endfunction

    // Accumulator value after the current stage: shift by 2^k only if shamt[k] is set.
    always_comb begin
        stage_amt_s = 5'd1 << k_r;
        acc_next_s  = acc_r;
        if (shamt_r[k_r]) begin
            acc_next_s = shift_stage(acc_r, op_r, stage_amt_s);
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Control FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            acc_r       <= 32'd0;
            shamt_r     <= 5'd0;
            op_r        <= 2'd0;
            k_r         <= 3'd0;
            out_data_r  <= 32'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            stage_r     <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc_r      <= in_data;
                        shamt_r    <= in_shamt;
                        op_r       <= in_op;
                        k_r        <= 3'd0;
                        stage_r    <= 3'd0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (FAST_ZERO && (in_shamt == 5'd0)) begin
                            // Nothing to shift: publish the operand right away.
                            state_r     <= ST_DONE;
                            out_data_r  <= in_data;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc_r <= acc_next_s;
                    if (k_r == 3'd4) begin
                        state_r     <= ST_DONE;
                        out_data_r  <= acc_next_s;
                        out_valid_r <= 1'b1;
                        k_r         <= 3'd0;
                        stage_r     <= 3'd0;
                    end else begin
                        k_r     <= k_r + 3'd1;
                        stage_r <= k_r + 3'd1;
                    end
                end
                ST_DONE: begin
                    // Result holds until taken; the new request waits one more cycle.
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b1;
                    k_r         <= 3'd0;
                    stage_r     <= 3'd0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign stage     = stage_r;

endmodule
